// File: rtl/tdc_echo_collect.sv
// Pairs TDC rise/fall edges into per-angle-window echo lists using ping-pong banks,
// then streams the closed window out one pair per cycle while the next window fills.
module tdc_echo_collect #(
    parameter int DATA_W   = 16,
    parameter int ANGLE_W  = 16,
    parameter int MAX_ECHO = 4
) (
    input  logic               i_clk_50m,
    input  logic               i_rst,
    input  logic               i_motor_state,
    input  logic               i_angle_sync,
    input  logic [ANGLE_W-1:0] i_code_angle,
    input  logic               i_rise_new_sig,
    input  logic               i_fall_new_sig,
    input  logic [DATA_W-1:0]  i_rise_data,
    input  logic [DATA_W-1:0]  i_fall_data,
    input  logic               i_rise_err_sig,
    input  logic               i_fall_err_sig,
    output logic               o_echo_valid,
    output logic [DATA_W-1:0]  o_rise_data,
    output logic [DATA_W-1:0]  o_fall_data,
    output logic [2:0]         o_echo_idx,
    output logic               o_echo_last,
    output logic [ANGLE_W-1:0] o_code_angle_tdc,
    output logic               o_win_ovf,
    output logic               o_flush_abort,
    output logic               o_tdc_err_sig
);

    localparam int CNT_W = $clog2(MAX_ECHO + 1);
    localparam int IDX_W = (MAX_ECHO > 1) ? $clog2(MAX_ECHO) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_ECHO);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;

    logic [1:0] state;
    logic       wr_bank;

    logic [1:0][MAX_ECHO-1:0][DATA_W-1:0] bank_rise;
    logic [1:0][MAX_ECHO-1:0][DATA_W-1:0] bank_fall;
    logic [1:0][CNT_W-1:0]                bank_cnt;
    logic [1:0][ANGLE_W-1:0]              bank_angle;
    logic [1:0]                           bank_ovf;

    logic              pend_vld;
    logic              pend_rise;
    logic [DATA_W-1:0] pend_data;

    logic             flush_act;
    logic             flush_bank;
    logic [IDX_W-1:0] flush_idx;

    // window control
    logic             win_sync;
    logic             win_start;
    logic             win_open;
    logic             open_bank;
    logic [CNT_W-1:0] base_cnt;
    logic             base_vld;
    logic             fl_last;

    // pairing result
    logic              st_en;
    logic [DATA_W-1:0] st_rise;
    logic [DATA_W-1:0] st_fall;
    logic              n_vld;
    logic              n_rise;
    logic [DATA_W-1:0] n_data;

    // closing-window half pair
    logic              cl_has;
    logic [DATA_W-1:0] cl_rise;
    logic [DATA_W-1:0] cl_fall;

    always_comb begin
        win_sync  = i_motor_state && i_angle_sync && (state == S_COLLECT);
        win_start = i_motor_state && i_angle_sync && (state == S_COLLECT || state == S_WAIT);
        win_open  = i_motor_state && (state == S_COLLECT || win_start);
        // edges coincident with a sync go into the freshly opened bank
        open_bank = win_sync ? ~wr_bank : wr_bank;
        base_cnt  = win_start ? '0 : bank_cnt[wr_bank];
        base_vld  = pend_vld && !win_start;
        fl_last   = (CNT_W'(flush_idx) + CNT_ONE) == bank_cnt[flush_bank];

        cl_has  = pend_vld || (bank_cnt[wr_bank] == '0);
        cl_rise = (pend_vld &&  pend_rise) ? pend_data : '0;
        cl_fall = (pend_vld && !pend_rise) ? pend_data : '0;
    end

    always_comb begin
        st_en   = 1'b0;
        st_rise = '0;
        st_fall = '0;
        n_vld   = base_vld;
        n_rise  = pend_rise;
        n_data  = pend_data;
        if (win_open) begin
            if (!base_vld) begin
                if (i_rise_new_sig && i_fall_new_sig) begin
                    st_en   = 1'b1;
                    st_rise = i_rise_data;
                    st_fall = i_fall_data;
                end else if (i_rise_new_sig) begin
                    n_vld  = 1'b1;
                    n_rise = 1'b1;
                    n_data = i_rise_data;
                end else if (i_fall_new_sig) begin
                    n_vld  = 1'b1;
                    n_rise = 1'b0;
                    n_data = i_fall_data;
                end
            end else if (pend_rise) begin
                if (i_fall_new_sig) begin
                    st_en   = 1'b1;
                    st_rise = pend_data;
                    st_fall = i_fall_data;
                    n_vld   = i_rise_new_sig;
                    n_rise  = 1'b1;
                    n_data  = i_rise_data;
                end else if (i_rise_new_sig) begin
                    st_en   = 1'b1;
                    st_rise = pend_data;
                    n_vld   = 1'b1;
                    n_rise  = 1'b1;
                    n_data  = i_rise_data;
                end
            end else begin
                if (i_rise_new_sig) begin
                    st_en   = 1'b1;
                    st_rise = i_rise_data;
                    st_fall = pend_data;
                    n_vld   = i_fall_new_sig;
                    n_rise  = 1'b0;
                    n_data  = i_fall_data;
                end else if (i_fall_new_sig) begin
                    st_en   = 1'b1;
                    st_fall = pend_data;
                    n_vld   = 1'b1;
                    n_rise  = 1'b0;
                    n_data  = i_fall_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state            <= S_IDLE;
            wr_bank          <= 1'b0;
            bank_rise        <= '0;
            bank_fall        <= '0;
            bank_cnt         <= '0;
            bank_angle       <= '0;
            bank_ovf         <= '0;
            pend_vld         <= 1'b0;
            pend_rise        <= 1'b0;
            pend_data        <= '0;
            flush_act        <= 1'b0;
            flush_bank       <= 1'b0;
            flush_idx        <= '0;
            o_echo_valid     <= 1'b0;
            o_rise_data      <= '0;
            o_fall_data      <= '0;
            o_echo_idx       <= '0;
            o_echo_last      <= 1'b0;
            o_code_angle_tdc <= '0;
            o_win_ovf        <= 1'b0;
            o_flush_abort    <= 1'b0;
            o_tdc_err_sig    <= 1'b0;
        end else begin
            o_tdc_err_sig <= i_rise_err_sig | i_fall_err_sig;
            if (!i_motor_state) begin
                state         <= S_IDLE;
                pend_vld      <= 1'b0;
                bank_cnt      <= '0;
                bank_ovf      <= '0;
                flush_act     <= 1'b0;
                flush_idx     <= '0;
                o_flush_abort <= 1'b0;
                o_echo_valid  <= 1'b0;
                o_echo_last   <= 1'b0;
            end else begin
                o_echo_valid <= flush_act;
                o_echo_last  <= flush_act && fl_last;
                if (flush_act) begin
                    o_rise_data      <= bank_rise[flush_bank][flush_idx];
                    o_fall_data      <= bank_fall[flush_bank][flush_idx];
                    o_echo_idx       <= 3'(flush_idx);
                    o_code_angle_tdc <= bank_angle[flush_bank];
                    o_win_ovf        <= bank_ovf[flush_bank];
                    if (fl_last)
                        flush_act <= 1'b0;
                    else
                        flush_idx <= flush_idx + 1'b1;
                end

                case (state)
                    S_IDLE:  state <= S_WAIT;
                    S_WAIT:  if (i_angle_sync) state <= S_COLLECT;
                    default: state <= S_COLLECT;
                endcase

                if (win_sync) begin
                    // an empty window still reports one (0,0) pair
                    if (cl_has) begin
                        if (bank_cnt[wr_bank] != CNT_FULL) begin
                            bank_rise[wr_bank][IDX_W'(bank_cnt[wr_bank])] <= cl_rise;
                            bank_fall[wr_bank][IDX_W'(bank_cnt[wr_bank])] <= cl_fall;
                            bank_cnt[wr_bank] <= bank_cnt[wr_bank] + CNT_ONE;
                        end else begin
                            bank_ovf[wr_bank] <= 1'b1;
                        end
                    end
                    if (flush_act && !fl_last)
                        o_flush_abort <= 1'b1;
                    flush_act  <= 1'b1;
                    flush_idx  <= '0;
                    flush_bank <= wr_bank;
                    wr_bank    <= ~wr_bank;
                end

                if (win_start) begin
                    bank_cnt[open_bank]   <= '0;
                    bank_ovf[open_bank]   <= 1'b0;
                    bank_angle[open_bank] <= i_code_angle;
                end

                if (st_en) begin
                    if (base_cnt != CNT_FULL) begin
                        bank_rise[open_bank][IDX_W'(base_cnt)] <= st_rise;
                        bank_fall[open_bank][IDX_W'(base_cnt)] <= st_fall;
                        bank_cnt[open_bank] <= base_cnt + CNT_ONE;
                    end else begin
                        bank_ovf[open_bank] <= 1'b1;
                    end
                end

                pend_vld  <= n_vld;
                pend_rise <= n_rise;
                pend_data <= n_data;
            end
        end
    end

endmodule

// File: doc/tdc_echo_collect.md
TDC_ECHO_COLLECT -- requirements
Module: tdc_echo_collect

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning TDC rise/fall word width.
REQ-002 SHALL have parameter ANGLE_W, default 16, meaning encoder angle width.
REQ-003 SHALL have parameter MAX_ECHO, default 4, legal 1..8, meaning echo pairs stored per angle window.
REQ-004 SHALL have ports: i_clk_50m  in  1  system clock; i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have inputs: i_motor_state 1 motor locked; i_angle_sync 1 window-boundary pulse; i_code_angle ANGLE_W angle; i_rise_new_sig 1, i_fall_new_sig 1 edge strobes; i_rise_data DATA_W, i_fall_data DATA_W edge times; i_rise_err_sig 1, i_fall_err_sig 1 TDC errors.
REQ-006 SHALL have outputs: o_echo_valid 1 pair strobe; o_rise_data DATA_W; o_fall_data DATA_W; o_echo_idx 3 pair index; o_echo_last 1 final pair of window; o_code_angle_tdc ANGLE_W window angle; o_win_ovf 1 window dropped edges; o_flush_abort 1 sticky; o_tdc_err_sig 1.
REQ-007 The clock SHALL be i_clk_50m and reset SHALL be i_rst, one clock, synchronous active-high reset.

Function
REQ-008 SHALL implement states IDLE, WAIT_SYNC, COLLECT; any state with i_motor_state=0 SHALL go to IDLE next cycle, clearing pending half-pair, counts, and any active flush.
REQ-009 IDLE->WAIT_SYNC when i_motor_state=1; WAIT_SYNC->COLLECT on i_angle_sync, capturing i_code_angle as open-window angle, no flush.
REQ-010 SHALL hold two banks (ping-pong), each MAX_ECHO pairs plus count and angle; COLLECT writes the open bank.
REQ-011 Pairing in COLLECT: rise and fall same cycle, no pending -> store pair; rise only -> pending rise; fall only -> pending fall; opposite edge completes the pending pair.
REQ-012 Same-kind edge while pending (e.g. second rise) SHALL store pending with missing half 0, new edge becomes pending.
REQ-013 Both strobes while a half is pending SHALL complete pending pair with matching strobe; other edge becomes pending.
REQ-014 Pair store with count=MAX_ECHO SHALL be dropped and set the bank overflow flag; count SHALL saturate at MAX_ECHO.
REQ-015 On i_angle_sync in COLLECT: pending half SHALL be stored (missing half 0) if room; if count=0, one pair (0,0) SHALL be stored; banks swap; closed bank begins flush next cycle; new open bank cleared, angle=i_code_angle.
REQ-016 Edge strobes coincident with i_angle_sync SHALL belong to the new window.
REQ-017 Flush: one pair per cycle, o_echo_valid=1, o_echo_idx 0..count-1, o_echo_last=1 on final pair; o_code_angle_tdc and o_win_ovf SHALL hold the closed bank's angle and overflow flag for the whole flush.
REQ-018 Latency: first pair valid 2 cycles after the i_angle_sync cycle; flush lasts exactly count cycles.
REQ-019 i_angle_sync during an active flush SHALL abort remaining pairs (no o_echo_last), set o_flush_abort, start the new flush.
REQ-020 o_tdc_err_sig SHALL be registered OR of i_rise_err_sig, i_fall_err_sig (1-cycle latency), independent of state.
REQ-021 o_echo_valid, o_echo_last SHALL be 0 outside flush; data outputs hold last values.

Reset
REQ-022 On i_rst=1 at a clock edge: state IDLE; all banks, counts, flags, pending cleared; all outputs 0.
REQ-023 Reset mid-flush SHALL terminate flush next cycle with no further o_echo_valid.
REQ-024 o_flush_abort SHALL clear only by reset or motor-stop.

Verification
REQ-025 Motor up, sync@angle 0x0100, rise 0x0010+fall 0x0020 same cycle, sync@0x0200 -> one pair (0x0010,0x0020), idx0, last=1, angle 0x0100, 2 cycles after sync.
REQ-026 Window with rise 0x0A, rise 0x0B, fall 0x0C -> pairs (0x0A,0),(0x0B,0x0C), idx 0,1, last on idx1.
REQ-027 MAX_ECHO=4, six complete pairs in window -> four pairs flushed, o_win_ovf=1, last on idx3.
REQ-028 Empty window -> single pair (0,0), last=1; fall-only pending at sync -> (0,fall).
REQ-029 Syncs 2 cycles apart with 4-pair window -> 2 pairs, no last, o_flush_abort=1; motor drop -> IDLE, abort clears.
REQ-030 i_rst=1 during flush -> o_echo_valid 0 next cycle, all outputs 0; i_rise_err_sig pulse -> o_tdc_err_sig one cycle later.
